// File: rtl/execute_in_stage_pkg.sv
// Shared types and default widths for the LC-3 execute-input buffer.
// The bundle struct is the default payload of the skid FIFO.
package execute_in_stage_pkg;

    localparam int DATA_W_D  = 16;
    localparam int NUM_BYP_D = 2;
    localparam int DEPTH_D   = 2;
    localparam int ECTRL_W_D = 6;
    localparam int WCTRL_W_D = 2;

    typedef struct packed {
        logic [DATA_W_D-1:0]  ir;
        logic [DATA_W_D-1:0]  npc;
        logic [DATA_W_D-1:0]  op1;
        logic [DATA_W_D-1:0]  op2;
        logic [ECTRL_W_D-1:0] e_ctrl;
        logic                 mem_ctrl;
        logic [WCTRL_W_D-1:0] w_ctrl;
    } exec_bundle_t;

    function automatic int sel_w(input int num_byp);
        return $clog2(num_byp + 1);
    endfunction

endpackage

// File: rtl/exec_skid_fifo.sv
// DEPTH-entry FIFO of execute bundles with count, pointers and flush.
// Head data falls back to the last popped entry while empty.
module exec_skid_fifo
    import execute_in_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter type T = exec_bundle_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  T                 i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output T                 o_data,
    output logic [CNT_W-1:0] o_count
);

    T                 r_mem [DEPTH];
    T                 r_hold;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_nxt;

    assign o_ready = (r_count < CNT_W'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;
    assign o_count = r_count;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_hold;

    assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
                r_hold   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_in_stage.sv
// Execute-stage input buffer: resolves operand bypass at capture time
// and queues the resolved bundle in a skid FIFO for the ALU.
module execute_in_stage
    import execute_in_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_D,
    parameter int NUM_BYP = NUM_BYP_D,
    parameter int DEPTH   = DEPTH_D,
    parameter int ECTRL_W = ECTRL_W_D,
    parameter int WCTRL_W = WCTRL_W_D,
    localparam int SEL_W  = sel_w(NUM_BYP),
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         ir,
    input  logic [DATA_W-1:0]         npc_in,
    input  logic [DATA_W-1:0]         vsr1,
    input  logic [DATA_W-1:0]         vsr2,
    input  logic [ECTRL_W-1:0]        e_control,
    input  logic                      mem_control_in,
    input  logic [WCTRL_W-1:0]        w_control_in,
    input  logic [SEL_W-1:0]          byp_sel1,
    input  logic [SEL_W-1:0]          byp_sel2,
    input  logic [NUM_BYP*DATA_W-1:0] byp_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_ir,
    output logic [DATA_W-1:0]         out_npc,
    output logic [DATA_W-1:0]         out_op1,
    output logic [DATA_W-1:0]         out_op2,
    output logic [ECTRL_W-1:0]        out_e_control,
    output logic                      out_mem_control,
    output logic [WCTRL_W-1:0]        out_w_control,
    output logic [OCC_W-1:0]          occupancy,
    output logic                      sel_err
);

    typedef struct packed {
        logic [DATA_W-1:0]  ir;
        logic [DATA_W-1:0]  npc;
        logic [DATA_W-1:0]  op1;
        logic [DATA_W-1:0]  op2;
        logic [ECTRL_W-1:0] e_ctrl;
        logic               mem_ctrl;
        logic [WCTRL_W-1:0] w_ctrl;
    } bundle_t;

    bundle_t           w_in;
    bundle_t           w_out;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_bad1;
    logic              w_bad2;
    logic              w_push;
    logic              r_sel_err;

    // Out-of-range selects fall back to the register-file operand.
    always_comb begin
        w_op1  = vsr1;
        w_op2  = vsr2;
        w_bad1 = (byp_sel1 > SEL_W'(NUM_BYP));
        w_bad2 = (byp_sel2 > SEL_W'(NUM_BYP));
        for (int k = 1; k <= NUM_BYP; k++) begin
            if (byp_sel1 == SEL_W'(k)) begin
                w_op1 = byp_val[(k-1)*DATA_W +: DATA_W];
            end
            if (byp_sel2 == SEL_W'(k)) begin
                w_op2 = byp_val[(k-1)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_in          = '0;
        w_in.ir       = ir;
        w_in.npc      = npc_in;
        w_in.op1      = w_op1;
        w_in.op2      = w_op2;
        w_in.e_ctrl   = e_control;
        w_in.mem_ctrl = mem_control_in;
        w_in.w_ctrl   = w_control_in;
    end

    assign w_push = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel_err <= 1'b0;
        end else if (w_push && (w_bad1 || w_bad2)) begin
            r_sel_err <= 1'b1;
        end
    end

    exec_skid_fifo #(
        .DEPTH (DEPTH),
        .T     (bundle_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out),
        .o_count (occupancy)
    );

    assign out_ir          = w_out.ir;
    assign out_npc         = w_out.npc;
    assign out_op1         = w_out.op1;
    assign out_op2         = w_out.op2;
    assign out_e_control   = w_out.e_ctrl;
    assign out_mem_control = w_out.mem_ctrl;
    assign out_w_control   = w_out.w_ctrl;
    assign sel_err         = r_sel_err;

endmodule

// File: tb/tb_execute_in_stage.sv
// Directed bench for execute_in_stage with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_execute_in_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ir;
    logic [15:0] npc_in;
    logic [15:0] vsr1;
    logic [15:0] vsr2;
    logic [5:0]  e_control;
    logic        mem_control_in;
    logic [1:0]  w_control_in;
    logic [1:0]  byp_sel1;
    logic [1:0]  byp_sel2;
    logic [31:0] byp_val;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ir;
    logic [15:0] out_npc;
    logic [15:0] out_op1;
    logic [15:0] out_op2;
    logic [5:0]  out_e_control;
    logic        out_mem_control;
    logic [1:0]  out_w_control;
    logic [1:0]  occupancy;
    logic        sel_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    execute_in_stage dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .ir              (ir),
        .npc_in          (npc_in),
        .vsr1            (vsr1),
        .vsr2            (vsr2),
        .e_control       (e_control),
        .mem_control_in  (mem_control_in),
        .w_control_in    (w_control_in),
        .byp_sel1        (byp_sel1),
        .byp_sel2        (byp_sel2),
        .byp_val         (byp_val),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ir          (out_ir),
        .out_npc         (out_npc),
        .out_op1         (out_op1),
        .out_op2         (out_op2),
        .out_e_control   (out_e_control),
        .out_mem_control (out_mem_control),
        .out_w_control   (out_w_control),
        .occupancy       (occupancy),
        .sel_err         (sel_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] i_ir, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] s1,
                         input logic [1:0] s2);
        in_valid       = 1'b1;
        ir             = i_ir;
        npc_in         = i_ir + 16'h1;
        vsr1           = a;
        vsr2           = b;
        byp_sel1       = s1;
        byp_sel2       = s2;
        e_control      = 6'h2A;
        mem_control_in = 1'b1;
        w_control_in   = 2'b10;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ir = '0; npc_in = '0; vsr1 = '0; vsr2 = '0; e_control = '0;
        mem_control_in = 1'b0; w_control_in = '0;
        byp_sel1 = '0; byp_sel2 = '0; byp_val = '0;
        step(); step();
        reset = 1'b1;
        step();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_occ", 32'(occupancy), 32'h0);
        check("rst_err", 32'(sel_err), 32'h0);
        check("rst_data", {out_ir, out_op1}, 32'h0);
        check("rst_data2", {out_npc, out_op2}, 32'h0);
        check("rst_ctrl", {23'h0, out_e_control, out_mem_control,
              out_w_control}, 32'h0);

        // single push, popped the following edge
        out_ready = 1'b1;
        drive(16'h1042, 16'h0005, 16'h0003, 2'd0, 2'd0);
        step();
        in_valid = 1'b0;
        check("p1_valid", 32'(out_valid), 32'h1);
        check("p1_op", {out_op1, out_op2}, 32'h0005_0003);
        check("p1_ir", {out_ir, out_npc}, 32'h1042_1043);
        check("p1_ctrl", {23'h0, out_e_control, out_mem_control,
              out_w_control}, {23'h0, 6'h2A, 1'b1, 2'b10});
        check("p1_occ", 32'(occupancy), 32'h1);
        step();
        check("p1_pop", {30'h0, out_valid, in_ready}, 32'h1);
        check("p1_hold", 32'(out_ir), 32'h1042);

        // bypass from both sources
        out_ready = 1'b0;
        byp_val = 32'h5555_AAAA;
        drive(16'h2000, 16'h1111, 16'h2222, 2'd1, 2'd2);
        step();
        in_valid = 1'b0;
        check("byp_op", {out_op1, out_op2}, 32'hAAAA_5555);
        check("byp_err", 32'(sel_err), 32'h0);
        byp_val = 32'h0;
        out_ready = 1'b1;
        step();
        check("byp_pop", 32'(occupancy), 32'h0);

        // backpressure with DEPTH=2, then in-order drain
        out_ready = 1'b0;
        drive(16'h0001, 16'h0, 16'h0, 2'd0, 2'd0);
        step();
        drive(16'h0002, 16'h0, 16'h0, 2'd0, 2'd0);
        step();
        check("bp_full", {30'h0, occupancy}, 32'h2);
        check("bp_ready", 32'(in_ready), 32'h0);
        drive(16'h0003, 16'h0, 16'h0, 2'd0, 2'd0);
        step();
        check("bp_held", {14'h0, occupancy, out_ir}, 32'h2_0001);
        out_ready = 1'b1;
        step();
        check("bp_pop1", {14'h0, occupancy, out_ir}, 32'h1_0002);
        check("bp_rdy1", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("bp_pop2", {14'h0, occupancy, out_ir}, 32'h1_0003);
        step();
        check("bp_drain", {14'h0, occupancy, 15'h0, out_valid}, 32'h0);

        // illegal select falls back and sticks through flush
        out_ready = 1'b0;
        drive(16'h3000, 16'hBEEF, 16'h0042, 2'd3, 2'd0);
        byp_val = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        check("ill_op", {out_op1, out_op2}, 32'hBEEF_0042);
        check("ill_err", 32'(sel_err), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("ill_flush", {30'h0, occupancy}, 32'h0);
        check("ill_sticky", 32'(sel_err), 32'h1);

        // flush at full with a push presented
        drive(16'h0010, 16'h0, 16'h0, 2'd0, 2'd0);
        step();
        drive(16'h0011, 16'h0, 16'h0, 2'd0, 2'd0);
        step();
        check("fl_full", {30'h0, occupancy}, 32'h2);
        drive(16'h0012, 16'h0, 16'h0, 2'd0, 2'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_empty", {14'h0, occupancy, 15'h0, out_valid}, 32'h0);
        // flush with a push that would otherwise be accepted
        drive(16'h0020, 16'h0, 16'h0, 2'd0, 2'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_push", {14'h0, occupancy, 15'h0, out_valid}, 32'h0);
        step();
        check("fl_never", {14'h0, occupancy, 15'h0, out_valid}, 32'h0);

        // asynchronous reset mid-stream
        drive(16'h0030, 16'h0, 16'h0, 2'd0, 2'd0);
        step();
        in_valid = 1'b0;
        check("ar_pre", 32'(occupancy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_empty", {14'h0, occupancy, 15'h0, out_valid}, 32'h0);
        check("ar_clear", {out_ir, 15'h0, sel_err}, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("ar_ready", 32'(in_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
